// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Imported by rr_arb2 and dmem_arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic port_t;

    localparam port_t PORT_CPU = 1'b0;
    localparam port_t PORT_DBG = 1'b1;

    localparam int WORD_BYTES = 8;
    localparam int WORD_SHIFT = 3;

    // The port that is not p; used to rotate the priority pointer.
    function automatic port_t other_port(input port_t p);
        return (p == PORT_CPU) ? PORT_DBG : PORT_CPU;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker.
// The pointer port wins a tie; a lone requester always wins.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      ptr,
    output logic [1:0] gnt,
    output port_t      winner
);

    // Grant the pointer port on a tie, otherwise whichever port asks.
    always_comb begin
        gnt[0] = req[0] & ((ptr == PORT_CPU) | ~req[1]);
        gnt[1] = req[1] & ((ptr == PORT_DBG) | ~req[0]);
        if (gnt[1]) begin
            winner = PORT_DBG;
        end else begin
            winner = PORT_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-ported 64-bit data
// memory. CPU (port 0) and debug/DMA (port 1) share the memory with a
// round-robin grant; each access holds the strobe for LAT cycles and then
// returns a one-cycle RVALID pulse.
// Optional build macro: DMEM_ARB_ALIGN_CHK_EN enables misalignment errors.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW  = 5,
    parameter int LAT = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [63:0]   CPU_ADDR,
    input  logic [63:0]   CPU_WDATA,
    output logic          CPU_GNT,
    output logic          CPU_RVALID,
    output logic [63:0]   CPU_RDATA,
    output logic          CPU_ERR,
    input  logic          DBG_REQ,
    input  logic          DBG_WE,
    input  logic [63:0]   DBG_ADDR,
    input  logic [63:0]   DBG_WDATA,
    output logic          DBG_GNT,
    output logic          DBG_RVALID,
    output logic [63:0]   DBG_RDATA,
    output logic          DBG_ERR,
    output logic          MEM_READ,
    output logic          MEM_WRITE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [63:0]   MEM_WR_DATA,
    input  logic [63:0]   MEM_RD_DATA
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    state_t        state_q, state_d;
    port_t         owner_q, owner_d;
    port_t         ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [63:0]   cpu_rdata_q, cpu_rdata_d;
    logic [63:0]   dbg_rdata_q, dbg_rdata_d;

    logic [1:0]    arb_gnt_s;
    logic [1:0]    gnt_s;
    port_t         winner_s;
    logic          win_we_s;
    logic [63:0]   win_addr_s;
    logic [63:0]   win_wdata_s;
    logic          misalign_s;
    logic          unused_s;

    rr_arb2 u_rr_arb2 (
        .req    ({DBG_REQ, CPU_REQ}),
        .ptr    (ptr_q),
        .gnt    (arb_gnt_s),
        .winner (winner_s)
    );

    // Grants only exist in IDLE and never while reset is asserted.
    always_comb begin
        if (state_q == IDLE) begin
            gnt_s = arb_gnt_s & {2{RST_N}};
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Select the winning port's request fields for latching.
    always_comb begin
        if (winner_s == PORT_DBG) begin
            win_we_s    = DBG_WE;
            win_addr_s  = DBG_ADDR;
            win_wdata_s = DBG_WDATA;
        end else begin
            win_we_s    = CPU_WE;
            win_addr_s  = CPU_ADDR;
            win_wdata_s = CPU_WDATA;
        end
    end

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign misalign_s = (win_addr_s[WORD_SHIFT-1:0] != 3'b000);
`else
    assign misalign_s = 1'b0;
`endif

    // Address bits outside the word index are intentionally ignored.
    assign unused_s = ^{win_addr_s[63:AW+WORD_SHIFT], win_addr_s[WORD_SHIFT-1:0], err_q};

    // Next-state logic: grant/latch in IDLE, count down in ACCESS, rotate in RESP.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_s != 2'b00) begin
                    owner_d = winner_s;
                    we_d    = win_we_s;
                    addr_d  = win_addr_s[AW+WORD_SHIFT-1:WORD_SHIFT];
                    wdata_d = win_wdata_s;
                    cnt_d   = CNT_LOAD;
                    err_d   = misalign_s;
                    if (misalign_s) begin
                        // Misaligned: skip the memory and answer with zero data.
                        state_d = RESP;
                        if (winner_s == PORT_DBG) begin
                            dbg_rdata_d = 64'd0;
                        end else begin
                            cpu_rdata_d = 64'd0;
                        end
                    end else begin
                        state_d = ACCESS;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q == PORT_DBG) begin
                            dbg_rdata_d = MEM_RD_DATA;
                        end else begin
                            cpu_rdata_d = MEM_RD_DATA;
                        end
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                ptr_d   = other_port(owner_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            owner_q     <= PORT_CPU;
            ptr_q       <= PORT_CPU;
            we_q        <= 1'b0;
            addr_q      <= {AW{1'b0}};
            wdata_q     <= 64'd0;
            cnt_q       <= {CW{1'b0}};
            err_q       <= 1'b0;
            cpu_rdata_q <= 64'd0;
            dbg_rdata_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Output decode from the registered state so reset drops strobes at once.
    always_comb begin
        CPU_GNT    = gnt_s[0];
        DBG_GNT    = gnt_s[1];
        CPU_RVALID = 1'b0;
        DBG_RVALID = 1'b0;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        case (state_q)
            ACCESS: begin
                MEM_READ  = ~we_q;
                MEM_WRITE = we_q;
            end
            RESP: begin
                CPU_RVALID = (owner_q == PORT_CPU);
                DBG_RVALID = (owner_q == PORT_DBG);
            end
            default: begin
                MEM_READ  = 1'b0;
                MEM_WRITE = 1'b0;
            end
        endcase
`ifdef DMEM_ARB_ALIGN_CHK_EN
        CPU_ERR = CPU_RVALID & err_q;
        DBG_ERR = DBG_RVALID & err_q;
`else
        CPU_ERR = 1'b0;
        DBG_ERR = 1'b0;
`endif
    end

    assign MEM_ADDR    = addr_q;
    assign MEM_WR_DATA = wdata_q;
    assign CPU_RDATA   = cpu_rdata_q;
    assign DBG_RDATA   = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed transaction table,
// hand-written contention/reset sequences and a randomized phase checked
// against a timestamp-based reference model with a golden memory.
module tb_dmem_arbiter;

    localparam int AW  = 5;
    localparam int LAT = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [63:0]   cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic          cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
    logic [63:0]   cpu_rdata, dbg_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wr_data, mem_rd_data;
    logic          mem_clear;

    logic [63:0]   mem  [DEPTH];
    logic [63:0]   gold [DEPTH];

    int n_cmp = 0;
    int n_mis = 0;

    dmem_arbiter #(.AW(AW), .LAT(LAT)) dut (
        .CLK(clk), .RST_N(rst_n),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
        .CPU_GNT(cpu_gnt), .CPU_RVALID(cpu_rvalid), .CPU_RDATA(cpu_rdata), .CPU_ERR(cpu_err),
        .DBG_REQ(dbg_req), .DBG_WE(dbg_we), .DBG_ADDR(dbg_addr), .DBG_WDATA(dbg_wdata),
        .DBG_GNT(dbg_gnt), .DBG_RVALID(dbg_rvalid), .DBG_RDATA(dbg_rdata), .DBG_ERR(dbg_err),
        .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDR(mem_addr),
        .MEM_WR_DATA(mem_wr_data), .MEM_RD_DATA(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural single-ported memory: combinational read, clocked write.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wr_data;
        end
    end
    assign mem_rd_data = mem[mem_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic clr);
        rst_n = 1'b0; mem_clear = clr;
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (3) @(posedge clk);
        #1; mem_clear = 1'b0; rst_n = 1'b1;
    endtask

    // One transaction on port p; returns observations, ends one cycle after RVALID.
    task automatic run_txn(input logic p, input logic we, input logic [63:0] addr,
                           input logic [63:0] wd, output logic [63:0] rd, output logic er,
                           output int gw, output int rl, output int ns,
                           output logic [AW-1:0] sa, output logic sw);
        logic got;
        rd = 64'd0; er = 1'b0; gw = 0; rl = 0; ns = 0; sa = '0; sw = 1'b0;
        if (p) begin
            dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        end
        got = 1'b0;
        while (!got && gw < 20) begin
            @(negedge clk);
            if ((p ? dbg_gnt : cpu_gnt) === 1'b1) got = 1'b1;
            else gw++;
            @(posedge clk); #1;
        end
        chk("txn_granted", {63'd0, got}, 64'd1);
        if (p) dbg_req = 1'b0; else cpu_req = 1'b0;
        got = 1'b0;
        while (!got && rl < 20) begin
            rl++;
            @(negedge clk);
            if (mem_read || mem_write) begin
                ns++; sa = mem_addr; sw = mem_write;
            end
            if ((p ? dbg_rvalid : cpu_rvalid) === 1'b1) begin
                got = 1'b1;
                rd = p ? dbg_rdata : cpu_rdata;
                er = p ? dbg_err : cpu_err;
            end
            @(posedge clk); #1;
        end
        chk("txn_rvalid_seen", {63'd0, got}, 64'd1);
    endtask

    typedef struct {
        logic          p;
        logic          we;
        logic [63:0]   addr;
        logic [63:0]   wd;
        logic [63:0]   exp_rd;
        logic          exp_err;
        int            exp_strobes;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t tbl [9];

    logic [63:0]   rd;
    logic          er, sw;
    int            gw, rl, ns;
    logic [AW-1:0] sa;

    // Random-phase reference model state
    logic          pend [2];
    logic          pw   [2];
    logic [63:0]   pa   [2];
    logic [63:0]   pd   [2];
    int            free_at, rv_at, acc_lo, acc_hi;
    logic          prio, rv_port, rv_we, g, in_acc;
    logic [63:0]   rv_data, rv_wd;
    logic [AW-1:0] acc_idx;
    logic [1:0]    exp_g;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 64'h18, 64'hDEADBEEF, 64'h0, 1'b0, LAT, 5'd3};
        tbl[1] = '{1'b0, 1'b0, 64'h18, 64'h0, 64'hDEADBEEF, 1'b0, LAT, 5'd3};
        tbl[2] = '{1'b1, 1'b1, 64'h20, 64'h0123456789ABCDEF, 64'h0, 1'b0, LAT, 5'd4};
        tbl[3] = '{1'b0, 1'b0, 64'h20, 64'h0, 64'h0123456789ABCDEF, 1'b0, LAT, 5'd4};
        tbl[4] = '{1'b1, 1'b0, 64'h118, 64'h0, 64'hDEADBEEF, 1'b0, LAT, 5'd3};
        tbl[5] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hA5A5_5A5A_0F0F_F0F0,
                   64'h0123456789ABCDEF, 1'b0, LAT, 5'd31};
        tbl[6] = '{1'b1, 1'b0, 64'hF8, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, LAT, 5'd31};
`ifdef DMEM_ARB_ALIGN_CHK_EN
        tbl[7] = '{1'b0, 1'b0, 64'h1C, 64'h0, 64'h0, 1'b1, 0, 5'd0};
`else
        tbl[7] = '{1'b0, 1'b0, 64'h1C, 64'h0, 64'hDEADBEEF, 1'b0, LAT, 5'd3};
`endif
        tbl[8] = '{1'b0, 1'b0, 64'h18, 64'h0, 64'hDEADBEEF, 1'b0, LAT, 5'd3};

        cpu_we = 1'b0; cpu_addr = 64'd0; cpu_wdata = 64'd0;
        dbg_we = 1'b0; dbg_addr = 64'd0; dbg_wdata = 64'd0;

        // Reset held with CPU requesting: nothing may be granted or strobed
        rst_n = 1'b0; mem_clear = 1'b1; cpu_req = 1'b1; dbg_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
            chk("rst_rvalid", {62'd0, cpu_rvalid, dbg_rvalid}, 64'd0);
            chk("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        end
        chk("rst_cpu_rdata", cpu_rdata, 64'd0);
        chk("rst_mem_addr", {59'd0, mem_addr}, 64'd0);
        chk("rst_mem_wr_data", mem_wr_data, 64'd0);
        @(posedge clk); #1;
        mem_clear = 1'b0; rst_n = 1'b1;
        run_txn(1'b0, 1'b0, 64'h0, 64'h0, rd, er, gw, rl, ns, sa, sw);
        chk("rst_release_gnt_wait", gw, 0);
        chk("rst_release_lat", rl, LAT + 1);

        // Directed transaction table
        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].p, tbl[i].we, tbl[i].addr, tbl[i].wd, rd, er, gw, rl, ns, sa, sw);
            chk($sformatf("v%0d_gnt_wait", i), gw, 0);
            chk($sformatf("v%0d_rv_lat", i), rl, (tbl[i].exp_strobes == 0) ? 1 : LAT + 1);
            chk($sformatf("v%0d_strobe_cycles", i), ns, tbl[i].exp_strobes);
            if (tbl[i].exp_strobes != 0) begin
                chk($sformatf("v%0d_mem_addr", i), {59'd0, sa}, {59'd0, tbl[i].exp_addr});
                chk($sformatf("v%0d_mem_write", i), {63'd0, sw}, {63'd0, tbl[i].we});
            end
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("v%0d_err", i), {63'd0, er}, {63'd0, tbl[i].exp_err});
        end

        // Both ports requesting continuously from reset: strict alternation
        begin
            int n, both;
            logic who [8];
            int   at  [8];
            n = 0; both = 0;
            rst_n = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
            cpu_addr = 64'h8; dbg_addr = 64'h10; cpu_req = 1'b1; dbg_req = 1'b1;
            repeat (2) @(posedge clk);
            #1; rst_n = 1'b1;
            for (int c = 0; c < 4 * (LAT + 2); c++) begin
                @(negedge clk);
                if (cpu_gnt && dbg_gnt) both++;
                if ((cpu_gnt || dbg_gnt) && n < 8) begin
                    who[n] = dbg_gnt; at[n] = c; n++;
                end
                @(posedge clk); #1;
            end
            cpu_req = 1'b0; dbg_req = 1'b0;
            chk("cont_both_gnt", both, 0);
            chk("cont_grants", n, 4);
            for (int k = 0; k < 4; k++) begin
                if (k < n) begin
                    chk($sformatf("cont_order%0d", k), {63'd0, who[k]}, k % 2);
                    chk($sformatf("cont_cycle%0d", k), at[k], k * (LAT + 2));
                end
            end
            repeat (LAT + 3) @(posedge clk);
            #1;
        end

        // Lone DBG wins despite CPU pointer; then CPU wins the tie
        do_reset(1'b0);
        run_txn(1'b1, 1'b0, 64'h20, 64'h0, rd, er, gw, rl, ns, sa, sw);
        chk("lone_dbg_gnt_wait", gw, 0);
        chk("lone_dbg_rdata", rd, 64'h0123456789ABCDEF);
        cpu_addr = 64'h18; cpu_we = 1'b0; dbg_addr = 64'h20; dbg_we = 1'b0;
        cpu_req = 1'b1; dbg_req = 1'b1;
        @(negedge clk);
        chk("tie_cpu_gnt", {62'd0, dbg_gnt, cpu_gnt}, 64'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        begin
            int k;
            k = 1;
            @(negedge clk);
            while (dbg_gnt !== 1'b1 && k < 20) begin
                @(posedge clk); #1; @(negedge clk); k++;
            end
            chk("tie_dbg_next_gap", k, LAT + 2);
        end
        @(posedge clk); #1;
        dbg_req = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;

        // Reset during ACCESS of a DBG load abandons it
        do_reset(1'b0);
        dbg_we = 1'b0; dbg_addr = 64'h18; dbg_req = 1'b1;
        @(negedge clk);
        chk("abort_dbg_gnt", {63'd0, dbg_gnt}, 64'd1);
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("abort_read_before", {63'd0, mem_read}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_strobes_now", {62'd0, mem_read, mem_write}, 64'd0);
        chk("abort_rvalid_now", {63'd0, dbg_rvalid}, 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_rvalid_held", {63'd0, dbg_rvalid}, 64'd0);
            chk("abort_strobes_held", {62'd0, mem_read, mem_write}, 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_txn(1'b0, 1'b0, 64'h18, 64'h0, rd, er, gw, rl, ns, sa, sw);
        chk("abort_idle_gnt_wait", gw, 0);
        chk("abort_after_rdata", rd, 64'hDEADBEEF);

        // Randomized traffic against the reference model
        do_reset(1'b1);
        for (int i = 0; i < DEPTH; i++) gold[i] = 64'd0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        free_at = 0; prio = 1'b0; rv_at = -1; acc_lo = -1; acc_hi = -2;
        rv_port = 1'b0; rv_we = 1'b0; rv_data = 64'd0; rv_wd = 64'd0; acc_idx = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    pw[p]   = 1'($urandom_range(0, 1));
                    pa[p]   = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFF8;
                    pd[p]   = {$urandom, $urandom};
                end
            end
            cpu_req = pend[0]; cpu_we = pw[0]; cpu_addr = pa[0]; cpu_wdata = pd[0];
            dbg_req = pend[1]; dbg_we = pw[1]; dbg_addr = pa[1]; dbg_wdata = pd[1];
            @(negedge clk);
            exp_g = 2'b00;
            if (cyc >= free_at) begin
                if (pend[0] && pend[1]) exp_g[prio] = 1'b1;
                else exp_g = {pend[1], pend[0]};
            end
            chk("rnd_gnt", {62'd0, dbg_gnt, cpu_gnt}, {62'd0, exp_g});
            chk("rnd_rvalid", {62'd0, dbg_rvalid, cpu_rvalid},
                {62'd0, (cyc == rv_at) && rv_port, (cyc == rv_at) && !rv_port});
            if (cyc == rv_at && !rv_we)
                chk("rnd_rdata", rv_port ? dbg_rdata : cpu_rdata, rv_data);
            in_acc = (cyc >= acc_lo) && (cyc <= acc_hi);
            chk("rnd_strobes", {62'd0, mem_read, mem_write}, {62'd0, in_acc && !rv_we, in_acc && rv_we});
            if (in_acc) begin
                chk("rnd_mem_addr", {59'd0, mem_addr}, {59'd0, acc_idx});
                if (rv_we) chk("rnd_mem_wr_data", mem_wr_data, rv_wd);
            end
            if (exp_g != 2'b00) begin
                g       = exp_g[1];
                rv_port = g;
                rv_we   = pw[g];
                rv_wd   = pd[g];
                acc_idx = pa[g][AW+2:3];
                rv_at   = cyc + LAT + 1;
                acc_lo  = cyc + 1;
                acc_hi  = cyc + LAT;
                free_at = cyc + LAT + 2;
                prio    = ~g;
                if (pw[g]) gold[acc_idx] = pd[g];
                else rv_data = gold[acc_idx];
                pend[g] = 1'b0;
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (LAT + 3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
